// File: rtl/itlb_micro_if.sv
// Fetch / joint-TLB facing bundle of the instruction micro-TLB.
// master = fetch + joint TLB side, slave = micro-TLB.
interface itlb_micro_if;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_uncached;
  logic        resp_refill;
  logic        resp_invalid;
  logic [31:0] tlb_vaddr;
  logic        tlb_found;
  logic        tlb_v;
  logic [31:0] tlb_paddr;
  logic        tlb_uncached;
  logic        tlb_write;
  logic [7:0]  asid;

  modport master (
    output req_valid, req_vaddr,
    output tlb_found, tlb_v, tlb_paddr,
    output tlb_uncached, tlb_write, asid,
    input  req_ready, resp_valid,
    input  resp_paddr, resp_uncached,
    input  resp_refill, resp_invalid,
    input  tlb_vaddr
  );

  modport slave (
    input  req_valid, req_vaddr,
    input  tlb_found, tlb_v, tlb_paddr,
    input  tlb_uncached, tlb_write, asid,
    output req_ready, resp_valid,
    output resp_paddr, resp_uncached,
    output resp_refill, resp_invalid,
    output tlb_vaddr
  );
endinterface

// File: rtl/itlb_micro.sv
// Instruction micro-TLB: small round-robin VPN->PFN cache in
// front of the joint TLB, with direct kseg0/kseg1 mapping.
module itlb_micro #(
  parameter int ENTRIES = 4
) (
  input logic        clk,
  input logic        resetn,
  itlb_micro_if.slave bus
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [PW-1:0] RR_LAST = PW'(ENTRIES - 1);

  typedef enum logic {IDLE, LOOKUP} state_e;

  state_e state_q, state_d;

  logic [ENTRIES-1:0] valid_q;
  logic [19:0]        vpn_q [ENTRIES];
  logic [19:0]        pfn_q [ENTRIES];
  logic [ENTRIES-1:0] unc_q;
  logic [PW-1:0]      rr_q;
  logic [7:0]         last_asid_q;
  logic [31:0]        vaddr_q;

  logic        rv_q, rv_d;
  logic [31:0] pa_q, pa_d;
  logic        uc_q, uc_d;
  logic        rf_q, rf_d;
  logic        iv_q, iv_d;

  logic        flush;
  logic        accept;
  logic        direct;
  logic        hit;
  logic [19:0] hit_pfn;
  logic        hit_unc;
  logic        fill;
  logic        ready;

  assign flush  = bus.tlb_write | (bus.asid != last_asid_q);
  assign accept = bus.req_valid & ready;
  assign direct = (bus.req_vaddr[31:30] == 2'b10);

  // Associative match; at most one entry can match a VPN.
  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    hit_unc = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && vpn_q[i] == bus.req_vaddr[31:12]) begin
        hit     = 1'b1;
        hit_pfn = pfn_q[i];
        hit_unc = unc_q[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: a miss, or a hit spoiled by flush, walks the jTLB.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept && !direct && !(hit && !flush))
          state_d = LOOKUP;
      LOOKUP:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake, next response and refill strobe.
  always_comb begin
    ready = 1'b0;
    fill  = 1'b0;
    rv_d  = 1'b0;
    pa_d  = '0;
    uc_d  = 1'b0;
    rf_d  = 1'b0;
    iv_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          if (direct) begin
            rv_d = 1'b1;
            pa_d = {3'b000, bus.req_vaddr[28:0]};
            uc_d = bus.req_vaddr[29];
          end else if (hit && !flush) begin
            rv_d = 1'b1;
            pa_d = {hit_pfn, bus.req_vaddr[11:0]};
            uc_d = hit_unc;
          end
        end
      end
      LOOKUP: begin
        rv_d = 1'b1;
        fill = bus.tlb_found & bus.tlb_v & ~flush;
        unique case (1'b1)
          bus.tlb_found & bus.tlb_v: begin
            pa_d = bus.tlb_paddr;
            uc_d = bus.tlb_uncached;
          end
          ~bus.tlb_found: rf_d = 1'b1;
          bus.tlb_found & ~bus.tlb_v: iv_d = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Entry array: flush wins over refill, refill goes to rr slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      unc_q   <= '0;
      rr_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        vpn_q[i] <= '0;
        pfn_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[rr_q] <= 1'b1;
      vpn_q[rr_q]   <= vaddr_q[31:12];
      pfn_q[rr_q]   <= bus.tlb_paddr[31:12];
      unc_q[rr_q]   <= bus.tlb_uncached;
      rr_q <= (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
    end
  end

  // ASID tracking and miss address latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_asid_q <= '0;
      vaddr_q     <= '0;
    end else begin
      last_asid_q <= bus.asid;
      if (state_q == IDLE && state_d == LOOKUP)
        vaddr_q <= bus.req_vaddr;
    end
  end

  // Registered one-cycle response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv_q <= 1'b0;
      pa_q <= '0;
      uc_q <= 1'b0;
      rf_q <= 1'b0;
      iv_q <= 1'b0;
    end else begin
      rv_q <= rv_d;
      pa_q <= pa_d;
      uc_q <= uc_d;
      rf_q <= rf_d;
      iv_q <= iv_d;
    end
  end

  assign bus.req_ready     = ready;
  assign bus.resp_valid    = rv_q;
  assign bus.resp_paddr    = pa_q;
  assign bus.resp_uncached = uc_q;
  assign bus.resp_refill   = rf_q;
  assign bus.resp_invalid  = iv_q;
  assign bus.tlb_vaddr     = vaddr_q;

endmodule

// File: tb/tb_itlb_micro.sv
// Bench for itlb_micro: directed scenarios plus random traffic
// against a FIFO-of-translations reference model.
module tb_itlb_micro;

  localparam int ENTRIES = 4;

  logic clk;
  logic resetn;

  itlb_micro_if bus ();

  itlb_micro #(.ENTRIES(ENTRIES)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Joint TLB stand-in: table indexed by vaddr[15:12].
  logic [15:0] jt_f;
  logic [15:0] jt_v;
  logic [15:0] jt_u;
  logic [19:0] jt_pfn [16];

  assign bus.tlb_found    = jt_f[bus.tlb_vaddr[15:12]];
  assign bus.tlb_v        = jt_v[bus.tlb_vaddr[15:12]];
  assign bus.tlb_uncached = jt_u[bus.tlb_vaddr[15:12]];
  assign bus.tlb_paddr    = {jt_pfn[bus.tlb_vaddr[15:12]],
                             bus.tlb_vaddr[11:0]};

  typedef struct {
    logic [19:0] vpn;
    logic [19:0] pfn;
    logic        unc;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy;
  logic [31:0] m_addr;
  logic [7:0]  m_last;
  logic [7:0]  cur_as;

  int total;
  int bad;

  logic        lr_v;
  logic [31:0] lr_pa;
  logic        lr_u;
  logic        lr_rf;
  logic        lr_iv;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit mhit(input logic [19:0] vpn, output ent_t e);
    e = '{vpn: '0, pfn: '0, unc: 1'b0};
    foreach (mq[i]) if (mq[i].vpn == vpn) begin
      e = mq[i];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: drive, predict, step, compare.
  task automatic cyc(input bit v, input logic [31:0] a, input bit w);
    bit          fl, fill, ev, eu, erf, eiv, nb;
    logic [31:0] epa;
    logic [3:0]  ix;
    ent_t        e, ne;
    bus.req_valid = v;
    bus.req_vaddr = a;
    bus.tlb_write = w;
    bus.asid      = cur_as;
    #1;
    chk("ready", 32'(bus.req_ready), 32'(!m_busy));
    if (m_busy) chk("tlb_vaddr", bus.tlb_vaddr, m_addr);
    fl = w || (cur_as != m_last);
    fill = 0; ev = 0; eu = 0; erf = 0; eiv = 0; epa = '0; nb = 0;
    ne = '{vpn: '0, pfn: '0, unc: 1'b0};
    if (m_busy) begin
      ix = m_addr[15:12];
      ev = 1;
      if (jt_f[ix] && jt_v[ix]) begin
        epa = {jt_pfn[ix], m_addr[11:0]};
        eu  = jt_u[ix];
        fill = !fl;
        ne = '{vpn: m_addr[31:12], pfn: jt_pfn[ix], unc: jt_u[ix]};
      end else if (!jt_f[ix]) erf = 1;
      else eiv = 1;
    end else if (v) begin
      if (a[31:30] == 2'b10) begin
        ev = 1;
        epa = {3'b000, a[28:0]};
        eu = (a[31:29] == 3'b101);
      end else if (!fl && mhit(a[31:12], e)) begin
        ev = 1;
        epa = {e.pfn, a[11:0]};
        eu = e.unc;
      end else begin
        nb = 1;
        m_addr = a;
      end
    end
    m_busy = nb;
    if (fl) mq.delete();
    if (fill) begin
      if (mq.size() == ENTRIES) void'(mq.pop_front());
      mq.push_back(ne);
    end
    m_last = cur_as;
    @(posedge clk);
    #1;
    lr_v = bus.resp_valid;
    lr_pa = bus.resp_paddr;
    lr_u = bus.resp_uncached;
    lr_rf = bus.resp_refill;
    lr_iv = bus.resp_invalid;
    chk("resp_valid", 32'(lr_v), 32'(ev));
    if (ev) begin
      chk("resp_paddr", lr_pa, epa);
      chk("resp_uncached", 32'(lr_u), 32'(eu));
      chk("resp_refill", 32'(lr_rf), 32'(erf));
      chk("resp_invalid", 32'(lr_iv), 32'(eiv));
    end
  endtask

  // Request and, on a miss, wait out the lookup cycle.
  task automatic req(input logic [31:0] a, output bit fast);
    cyc(1'b1, a, 1'b0);
    fast = lr_v;
    if (!fast) cyc(1'b0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] raddr();
    int unsigned r;
    logic [3:0]  n;
    r = $urandom_range(0, 9);
    n = 4'($urandom_range(0, 15));
    if (r == 0)
      return {2'b10, 1'($urandom_range(0, 1)), 29'($urandom)};
    if (r == 1)
      return {16'hC000, n, 12'($urandom)};
    return {16'h0040, n, 12'($urandom)};
  endfunction

  bit fast;

  initial begin
    total = 0; bad = 0;
    m_busy = 0; m_addr = '0; m_last = '0; cur_as = '0;
    resetn = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_vaddr = '0;
    bus.tlb_write = 1'b0;
    bus.asid = '0;
    for (int i = 0; i < 16; i++) begin
      jt_f[i] = 1'b1;
      jt_v[i] = 1'b1;
      jt_u[i] = 1'($urandom_range(0, 1));
      jt_pfn[i] = 20'($urandom);
    end
    jt_pfn[1] = 20'h01234;
    jt_u[1] = 1'b0;
    jt_f[7] = 1'b0;
    jt_v[8] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_paddr", bus.resp_paddr, 32'h0);
    chk("rst_unc", 32'(bus.resp_uncached), 32'd0);
    chk("rst_refill", 32'(bus.resp_refill), 32'd0);
    chk("rst_inval", 32'(bus.resp_invalid), 32'd0);
    chk("rst_tva", bus.tlb_vaddr, 32'h0);
    resetn = 1'b1;
    cur_as = 8'h01;

    // kseg1 direct translation
    req(32'hBFC0_0000, fast);
    chk("t1_fast", 32'(fast), 32'd1);
    chk("t1_pa", lr_pa, 32'h1FC0_0000);
    chk("t1_unc", 32'(lr_u), 32'd1);

    // miss then hit on the same page
    req(32'h0040_1234, fast);
    chk("t2_miss", 32'(fast), 32'd0);
    chk("t2_pa", lr_pa, 32'h0123_4234);
    req(32'h0040_1ABC, fast);
    chk("t2_hit", 32'(fast), 32'd1);
    chk("t2_hpa", lr_pa, 32'h0123_4ABC);

    // faults are returned but never cached
    req(32'h0040_7010, fast);
    chk("t3_rf", 32'(lr_rf), 32'd1);
    chk("t3_rfpa", lr_pa, 32'h0);
    req(32'h0040_7010, fast);
    chk("t3_again", 32'(fast), 32'd0);
    req(32'h0040_8020, fast);
    chk("t3_iv", 32'(lr_iv), 32'd1);

    // round-robin replacement
    for (int n = 2; n <= 6; n++) req({16'h0040, 4'(n), 12'h0}, fast);
    req(32'h0040_3004, fast);
    chk("t4_second_hit", 32'(fast), 32'd1);
    req(32'h0040_2004, fast);
    chk("t4_first_miss", 32'(fast), 32'd0);

    // ASID change and tlb_write flush
    req(32'h0040_9000, fast);
    cur_as = 8'h02;
    req(32'h0040_9000, fast);
    chk("t5_asid_miss", 32'(fast), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    req(32'h0040_9000, fast);
    chk("t5_wr_miss", 32'(fast), 32'd0);
    cyc(1'b1, 32'h0040_A000, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t5_wr_resp", 32'(lr_v), 32'd1);
    req(32'h0040_A000, fast);
    chk("t5_nofill", 32'(fast), 32'd0);

    // reset in the middle of a lookup
    req(32'h0040_B000, fast);
    cyc(1'b1, 32'h0040_C000, 1'b0);
    resetn = 1'b0;
    bus.req_valid = 1'b0;
    cur_as = 8'h00;
    bus.asid = cur_as;
    #1;
    chk("t6_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("t6_novalid", 32'(bus.resp_valid), 32'd0);
    resetn = 1'b1;
    mq.delete();
    m_busy = 0;
    m_last = '0;
    req(32'h0040_B000, fast);
    chk("t6_miss", 32'(fast), 32'd0);

    // random traffic
    for (int i = 0; i < 16; i++) begin
      jt_f[i] = ($urandom_range(0, 3) != 0);
      jt_v[i] = ($urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 3000; k++) begin
      bit w;
      if ($urandom_range(0, 49) == 0) cur_as = 8'($urandom_range(0, 3));
      w = ($urandom_range(0, 39) == 0);
      if (w) begin
        int j;
        j = $urandom_range(0, 15);
        jt_f[j] = ($urandom_range(0, 3) != 0);
        jt_v[j] = ($urandom_range(0, 3) != 0);
        jt_u[j] = 1'($urandom_range(0, 1));
        jt_pfn[j] = 20'($urandom);
      end
      cyc($urandom_range(0, 3) != 0, raddr(), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
